// File: rtl/vga_pixel_out_if.sv
// rtl/vga_pixel_out_if.sv - pixel stream bundle between the frame source and vga_pixel_out
// Signals:
//   data  : pixel word
//   sof   : marks the first pixel of a frame
//   valid : source has a word on data/sof
//   ready : sink accepts the word this cycle (transfer = valid && ready)
interface vga_pixel_out_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              valid;
    logic              ready;

    modport master (output data, output sof, output valid, input ready);
    modport slave  (input data, input sof, input valid, output ready);
endinterface

// File: rtl/vga_pixel_out.sv
// rtl/vga_pixel_out.sv - VGA output stage: registered RGB/sync/DE, coordinates, stream frame lock
// Ports:
//   clk_i, rst_ni        : pixel clock, asynchronous active-low reset
//   hde_i, vde_i         : data enables from the timing generator
//   hsyn_i, vsyn_i       : syncs with polarity already applied
//   eol_i, eof_i         : end-of-line / end-of-frame pulses (eof_i always with eol_i)
//   pix                  : pixel stream (slave side), carries a start-of-frame marker
//   rgb_o, de_o          : registered pixel and data enable
//   hsyn_o, vsyn_o       : registered syncs
//   x_o, y_o             : coordinate of the pixel on rgb_o, valid when de_o
//   locked_o             : stream is locked to the frame (RUN)
//   underflow_o          : one-cycle pulse, stream empty on an active pixel
//   misalign_o           : one-cycle pulse, SOF marker disagrees with the raster origin
//   err_cnt_o            : saturating count of underflow + misalign events
module vga_pixel_out #(
    parameter int                DATA_W     = 16,
    parameter int                X_W        = 11,
    parameter int                Y_W        = 10,
    parameter logic [DATA_W-1:0] FILL_COLOR = 16'hF800,
    parameter logic              SYNC_RST   = 1'b1,
    parameter int                CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              hde_i,
    input  logic              vde_i,
    input  logic              hsyn_i,
    input  logic              vsyn_i,
    input  logic              eol_i,
    input  logic              eof_i,
    vga_pixel_out_if.slave    pix,
    output logic [DATA_W-1:0] rgb_o,
    output logic              de_o,
    output logic              hsyn_o,
    output logic              vsyn_o,
    output logic [X_W-1:0]    x_o,
    output logic [Y_W-1:0]    y_o,
    output logic              locked_o,
    output logic              underflow_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_ARMED,
        ST_RUN
    } state_t;

    state_t         state;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           line_de;

    logic de;
    logic at_origin;
    logic underflow;
    logic misalign;
    logic err;

    assign de        = hde_i && vde_i;
    assign at_origin = (x_cnt == '0) && (y_cnt == '0);
    assign underflow = (state == ST_RUN) && de && !pix.valid;
    // A SOF word must land exactly on (0,0) and no other word may.
    assign misalign  = (state == ST_RUN) && de && pix.valid && (pix.sof != at_origin);
    assign err       = underflow || misalign;

    // FLUSH drains everything up to (not including) the next SOF word; ARMED
    // holds that SOF word until the frame boundary; RUN pulls one word per
    // active pixel but refuses a misaligned word so it survives for relock.
    assign pix.ready = (state == ST_FLUSH) ? (pix.valid && !pix.sof) :
                       (state == ST_RUN)   ? (de && !misalign)       : 1'b0;

    // Timing path: never influenced by the stream state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_o   <= '0;
            de_o    <= 1'b0;
            hsyn_o  <= SYNC_RST;
            vsyn_o  <= SYNC_RST;
            x_o     <= '0;
            y_o     <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            line_de <= 1'b0;
        end else begin
            de_o   <= de;
            hsyn_o <= hsyn_i;
            vsyn_o <= vsyn_i;
            x_o    <= x_cnt;
            y_o    <= y_cnt;

            if (!de) begin
                rgb_o <= '0;
            end else if ((state != ST_RUN) || err) begin
                rgb_o <= FILL_COLOR;
            end else begin
                rgb_o <= pix.data;
            end

            if (eof_i) begin
                x_cnt   <= '0;
                y_cnt   <= '0;
                line_de <= 1'b0;
            end else if (eol_i) begin
                x_cnt <= '0;
                // Blank lines (vertical porch) do not advance y.
                if ((line_de || de) && (y_cnt != '1)) begin
                    y_cnt <= y_cnt + Y_W'(1);
                end
                line_de <= 1'b0;
            end else if (de) begin
                if (x_cnt != '1) begin
                    x_cnt <= x_cnt + X_W'(1);
                end
                line_de <= 1'b1;
            end
        end
    end

    // Stream lock FSM with its registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_FLUSH;
            locked_o    <= 1'b0;
            underflow_o <= 1'b0;
            misalign_o  <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            underflow_o <= underflow;
            misalign_o  <= misalign;
            if (err && (err_cnt_o != '1)) begin
                err_cnt_o <= err_cnt_o + CNT_W'(1);
            end

            case (state)
                ST_FLUSH: begin
                    if (pix.valid && pix.sof) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (eof_i) begin
                        state    <= ST_RUN;
                        locked_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (err) begin
                        state    <= ST_FLUSH;
                        locked_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_FLUSH;
                    locked_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pixel_out.sv
// tb/tb_vga_pixel_out.sv - self-checking bench for vga_pixel_out in an 8x4 tiny raster
module tb_vga_pixel_out;

    localparam logic [15:0] FILL = 16'hF800;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic hde, vde, hs, vs, eol, eof;
    logic [15:0] rgb_o;
    logic        de_o, hsyn_o, vsyn_o, locked_o, underflow_o, misalign_o;
    logic [10:0] x_o;
    logic [9:0]  y_o;
    logic [15:0] err_cnt_o;

    vga_pixel_out_if #(.DATA_W(16)) pif ();

    vga_pixel_out dut (
        .clk_i(clk), .rst_ni(rst_n),
        .hde_i(hde), .vde_i(vde), .hsyn_i(hs), .vsyn_i(vs),
        .eol_i(eol), .eof_i(eof),
        .pix(pif),
        .rgb_o(rgb_o), .de_o(de_o), .hsyn_o(hsyn_o), .vsyn_o(vsyn_o),
        .x_o(x_o), .y_o(y_o), .locked_o(locked_o),
        .underflow_o(underflow_o), .misalign_o(misalign_o), .err_cnt_o(err_cnt_o)
    );

    // Second instance with a narrow error counter for the saturation check.
    logic s_de, s_eol, s_eof;
    logic [15:0] s_rgb;
    logic        s_de_o, s_hs_o, s_vs_o, s_locked, s_uf, s_ma;
    logic [10:0] s_x;
    logic [9:0]  s_y;
    logic [3:0]  s_cnt;

    vga_pixel_out_if #(.DATA_W(16)) spif ();

    vga_pixel_out #(.CNT_W(4)) sat_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .hde_i(s_de), .vde_i(s_de), .hsyn_i(1'b1), .vsyn_i(1'b1),
        .eol_i(s_eol), .eof_i(s_eof),
        .pix(spif),
        .rgb_o(s_rgb), .de_o(s_de_o), .hsyn_o(s_hs_o), .vsyn_o(s_vs_o),
        .x_o(s_x), .y_o(s_y), .locked_o(s_locked),
        .underflow_o(s_uf), .misalign_o(s_ma), .err_cnt_o(s_cnt)
    );

    int tests = 0;
    int failed = 0;
    int cnt_exp = 0;

    typedef struct packed {
        logic        sof;
        logic [15:0] data;
    } word_t;
    word_t q[$];

    typedef struct {
        logic hde, vde, hs, vs;
        logic e_de, e_hs, e_vs;
        logic [15:0] e_rgb;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_out(input bit with_xy);
        return {6'b0, rgb_o, de_o, hsyn_o, vsyn_o, underflow_o, misalign_o, err_cnt_o,
                with_xy ? {x_o, y_o} : 21'b0};
    endfunction

    function automatic logic [63:0] mk(input logic [15:0] rgb, input logic d, input logic h,
                                       input logic v, input logic uf, input logic ma,
                                       input logic [15:0] cnt, input logic [10:0] x,
                                       input logic [9:0] y);
        return {6'b0, rgb, d, h, v, uf, ma, cnt, x, y};
    endfunction

    task automatic push_frame(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back({(i == 0), 16'(base + i)});
        end
    endtask

    task automatic idle_inputs();
        hde = 0; vde = 0; hs = 1; vs = 1; eol = 0; eof = 0;
        pif.valid = 0; pif.sof = 0; pif.data = '0;
    endtask

    // Called at posedge+1; asserts reset off-edge and checks the async effect.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_outs", pack_out(1'b1), mk(16'h0, 0, 1, 1, 0, 0, 16'h0, 11'd0, 10'd0));
        check("rst_locked", 64'(locked_o), 64'd0);
        idle_inputs();
        q.delete();
        cnt_exp = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One 12x6 frame (8x4 active). lk: frame expected locked from its start.
    // err_kind 1 drops valid at pixel err_idx; 2 expects a misalign there.
    task automatic run_frame(input bit lk, input int base, input int err_idx,
                             input int err_kind, input int ncyc);
        int cyc;
        bit d, xfer, e_uf, e_ma;
        int idx;
        logic [15:0] e_rgb;
        cyc = 0;
        for (int v = 0; v < 6; v++) begin
            for (int h = 0; h < 12; h++) begin
                if (cyc >= ncyc) return;
                cyc++;
                hde = (h < 8); vde = (v < 4);
                hs  = !(h == 9 || h == 10);
                vs  = !(v == 4);
                eol = (h == 11);
                eof = (h == 11) && (v == 5);
                d   = hde && vde;
                idx = v * 8 + h;
                if (q.size() > 0 && !(d && err_kind == 1 && idx == err_idx)) begin
                    pif.valid = 1; pif.sof = q[0].sof; pif.data = q[0].data;
                end else begin
                    pif.valid = 0; pif.sof = 0; pif.data = '0;
                end
                @(negedge clk);
                xfer = pif.valid && pif.ready;
                @(posedge clk); #1;
                if (xfer) void'(q.pop_front());
                e_uf = d && err_kind == 1 && idx == err_idx;
                e_ma = d && err_kind == 2 && idx == err_idx;
                if (e_uf || e_ma) cnt_exp++;
                if (!d) e_rgb = 16'h0;
                else if (!lk || (err_idx >= 0 && idx >= err_idx)) e_rgb = FILL;
                else e_rgb = 16'(base + idx);
                check($sformatf("frame%0d(%0d,%0d)", base, h, v), pack_out(d),
                      mk(e_rgb, d, hs, vs, e_uf, e_ma, 16'(cnt_exp),
                         d ? 11'(h) : 11'd0, d ? 10'(v) : 10'd0));
            end
        end
    endtask

    initial begin
        vt[0] = '{0, 0, 1, 1, 0, 1, 1, 16'h0000};
        vt[1] = '{0, 0, 0, 1, 0, 0, 1, 16'h0000};
        vt[2] = '{1, 1, 0, 0, 1, 0, 0, 16'hF800};
        vt[3] = '{1, 0, 1, 0, 0, 1, 0, 16'h0000};
        vt[4] = '{0, 1, 1, 1, 0, 1, 1, 16'h0000};
        vt[5] = '{1, 1, 1, 1, 1, 1, 1, 16'hF800};

        idle_inputs();
        s_de = 0; s_eol = 0; s_eof = 0;
        spif.valid = 0; spif.sof = 0; spif.data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", pack_out(1'b1), mk(16'h0, 0, 1, 1, 0, 0, 16'h0, 11'd0, 10'd0));
        check("reset_locked", 64'(locked_o), 64'd0);
        rst_n = 1'b1;

        // Latency table: outputs hold until the edge, then show the inputs.
        begin
            logic [18:0] prev;
            prev = {1'b0, 1'b1, 1'b1, 16'h0};
            for (int i = 0; i < 6; i++) begin
                hde = vt[i].hde; vde = vt[i].vde; hs = vt[i].hs; vs = vt[i].vs;
                #2;
                check($sformatf("lat_pre%0d", i), 64'({de_o, hsyn_o, vsyn_o, rgb_o}), 64'(prev));
                @(posedge clk); #1;
                prev = {vt[i].e_de, vt[i].e_hs, vt[i].e_vs, vt[i].e_rgb};
                check($sformatf("lat_post%0d", i), 64'({de_o, hsyn_o, vsyn_o, rgb_o}), 64'(prev));
            end
        end

        // Lock and show a 0..31 frame.
        do_reset();
        push_frame(0, 32);
        run_frame(0, 0, -1, 0, 999);
        check("t1_locked", 64'(locked_o), 64'd1);
        run_frame(1, 0, -1, 0, 999);
        check("t1_drained", 64'(q.size()), 64'd0);

        // Underflow at (3,1), then relock on the next frame.
        push_frame(32, 32);
        push_frame(64, 32);
        run_frame(1, 32, 11, 1, 999);
        check("uf_relocked", 64'(locked_o), 64'd1);
        check("uf_errcnt", 64'(err_cnt_o), 64'd1);
        check("uf_sof_held", 64'(q.size()), 64'd32);
        run_frame(1, 64, -1, 0, 999);

        // Early SOF landing at (5,2).
        push_frame(96, 21);
        push_frame(128, 32);
        run_frame(1, 96, 21, 2, 999);
        check("ma_relocked", 64'(locked_o), 64'd1);
        check("ma_errcnt", 64'(err_cnt_o), 64'd2);
        check("ma_sof_held", 64'(q.size()), 64'd32);
        run_frame(1, 128, -1, 0, 999);

        // Reset mid-line while running; relock needs SOF plus eof.
        push_frame(0, 32);
        run_frame(1, 0, -1, 0, 5);
        do_reset();
        push_frame(160, 32);
        run_frame(0, 0, -1, 0, 999);
        check("rst_relock", 64'(locked_o), 64'd1);
        run_frame(1, 160, -1, 0, 999);

        // Junk words ahead of SOF are flushed, SOF lands on (0,0).
        do_reset();
        for (int i = 0; i < 5; i++) q.push_back({1'b0, 16'(16'hBAD0 + i)});
        push_frame(224, 32);
        run_frame(0, 0, -1, 0, 999);
        check("junk_flushed", 64'(q.size()), 64'd32);
        check("junk_locked", 64'(locked_o), 64'd1);
        run_frame(1, 224, -1, 0, 999);
        idle_inputs();

        // Error counter saturation on the 4-bit instance (2^4+3 underflows).
        for (int k = 0; k < 19; k++) begin
            s_de = 0; s_eof = 0; s_eol = 0; spif.valid = 1; spif.sof = 1;
            @(posedge clk); #1;
            s_eof = 1; s_eol = 1;
            @(posedge clk); #1;
            s_eof = 0; s_eol = 0; s_de = 1; spif.valid = 0; spif.sof = 0;
            @(posedge clk); #1;
            if (k == 0) check("sat_pulse", 64'({s_uf, s_ma}), 64'd2);
            if (k == 2) check("sat_cnt3", 64'(s_cnt), 64'd3);
        end
        s_de = 0;
        @(posedge clk); #1;
        check("sat_cnt_max", 64'(s_cnt), 64'd15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
